// File: rtl/sdram_stream_writer.sv
// Stream-to-SDRAM DMA writer: buffers a valid/ready word stream in a FIFO and
// drains it as fixed-length Avalon-MM write bursts into a circular DDR buffer.
module sdram_stream_writer #(
   parameter int                 DATA_W     = 32,
   parameter int                 ADDR_W     = 32,
   parameter int                 BURST_LEN  = 8,
   parameter int                 FIFO_DEPTH = 64,
   parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h3000_0000,
   parameter int                 BUF_WORDS  = 4096
) (
   input  logic                              clk_clk,
   input  logic                              reset_reset_n,
   input  logic                              enable,
   input  logic                              flush,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_W-1:0]                 in_data,
   output logic [ADDR_W-1:0]                 avm_address,
   output logic [$clog2(BURST_LEN):0]        avm_burstcount,
   output logic                              avm_write,
   output logic [DATA_W-1:0]                 avm_writedata,
   output logic [DATA_W/8-1:0]               avm_byteenable,
   input  logic                              avm_waitrequest,
   output logic [$clog2(BUF_WORDS)-1:0]      wr_ptr,
   output logic                              burst_done
);

   localparam int BC_W  = $clog2(BURST_LEN) + 1;
   localparam int PTR_W = $clog2(BUF_WORDS);
   localparam int FA_W  = $clog2(FIFO_DEPTH);
   localparam int FC_W  = FA_W + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t              state_q, state_d;
   logic [FA_W-1:0]     fifo_wp_q, fifo_wp_d;
   logic [FA_W-1:0]     fifo_rp_q, fifo_rp_d;
   logic [FC_W-1:0]     fifo_cnt_q, fifo_cnt_d;
   logic                flush_q, flush_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic                avm_write_q, avm_write_d;
   logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
   logic [BC_W-1:0]     avm_burstcount_q, avm_burstcount_d;
   logic [BC_W-1:0]     beats_left_q, beats_left_d;
   logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

   logic                push;
   logic                beat;
   logic                last_beat;
   logic                start;
   logic                below_burst;
   logic [BC_W-1:0]     n_beats;

   // Burst length limited by burst size, FIFO fill and distance to the ring end.
   function automatic logic [BC_W-1:0] calc_burst(input logic [FC_W-1:0] cnt,
                                                  input logic [PTR_W-1:0] ptr);
      int n;
      int room;
      room = BUF_WORDS - int'(ptr);
      n    = BURST_LEN;
      if (int'(cnt) < n) n = int'(cnt);
      if (room < n) n = room;
      return BC_W'(n);
   endfunction

   assign in_ready       = enable & reset_reset_n & (fifo_cnt_q < FC_W'(FIFO_DEPTH));
   assign push           = in_valid & in_ready;
   assign beat           = (state_q == BURST) & avm_write_q & ~avm_waitrequest;
   assign last_beat      = beat & (beats_left_q == BC_W'(1));
   assign below_burst    = fifo_cnt_q < FC_W'(BURST_LEN);
   assign start          = (state_q == IDLE) & enable &
                           (~below_burst | (flush_q & (fifo_cnt_q != '0)));
   assign n_beats        = calc_burst(fifo_cnt_q, wr_ptr_q);

   assign avm_address    = avm_address_q;
   assign avm_burstcount = avm_burstcount_q;
   assign avm_write      = avm_write_q;
   assign avm_writedata  = mem_q[fifo_rp_q];
   assign avm_byteenable = '1;
   assign wr_ptr         = wr_ptr_q;
   assign burst_done     = last_beat;

   always_comb begin
      state_d          = state_q;
      fifo_wp_d        = fifo_wp_q;
      fifo_rp_d        = fifo_rp_q;
      fifo_cnt_d       = fifo_cnt_q;
      flush_d          = flush_q;
      wr_ptr_d         = wr_ptr_q;
      avm_write_d      = avm_write_q;
      avm_address_d    = avm_address_q;
      avm_burstcount_d = avm_burstcount_q;
      beats_left_d     = beats_left_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d          = BURST;
               avm_write_d      = 1'b1;
               avm_address_d    = BASE_ADDR + (ADDR_W'(wr_ptr_q) << 2);
               avm_burstcount_d = n_beats;
               beats_left_d     = n_beats;
               if (flush_q & below_burst) flush_d = 1'b0;
            end
         end
         BURST: begin
            if (beat) beats_left_d = beats_left_q - BC_W'(1);
            if (last_beat) begin
               state_d     = IDLE;
               avm_write_d = 1'b0;
               // Ring size is a power of two, so the pointer wraps by truncation.
               wr_ptr_d    = wr_ptr_q + PTR_W'(avm_burstcount_q);
            end
         end
         default: state_d = IDLE;
      endcase

      // A flush seen with an empty FIFO has nothing to write and is dropped.
      if (flush) flush_d = (fifo_cnt_q != '0);

      if (push) fifo_wp_d = fifo_wp_q + FA_W'(1);
      if (beat) fifo_rp_d = fifo_rp_q + FA_W'(1);
      case ({push, beat})
         2'b10:   fifo_cnt_d = fifo_cnt_q + FC_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - FC_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q          <= IDLE;
         fifo_wp_q        <= '0;
         fifo_rp_q        <= '0;
         fifo_cnt_q       <= '0;
         flush_q          <= 1'b0;
         wr_ptr_q         <= '0;
         avm_write_q      <= 1'b0;
         avm_address_q    <= BASE_ADDR;
         avm_burstcount_q <= '0;
         beats_left_q     <= '0;
      end else begin
         state_q          <= state_d;
         fifo_wp_q        <= fifo_wp_d;
         fifo_rp_q        <= fifo_rp_d;
         fifo_cnt_q       <= fifo_cnt_d;
         flush_q          <= flush_d;
         wr_ptr_q         <= wr_ptr_d;
         avm_write_q      <= avm_write_d;
         avm_address_q    <= avm_address_d;
         avm_burstcount_q <= avm_burstcount_d;
         beats_left_q     <= beats_left_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push) mem_q[fifo_wp_q] <= in_data;
   end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// Randomized bench for sdram_stream_writer: a queue-based reference model of the
// FIFO and ring pointer predicts every output each cycle (ring shrunk to 16 words).
module tb_sdram_stream_writer;

   localparam int          BUF   = 16;
   localparam int          BLEN  = 8;
   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [31:0] avm_address;
   logic [3:0]  avm_burstcount;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        wt;
   logic [3:0]  wr_ptr;
   logic        burst_done;

   always #5 clk = ~clk;

   sdram_stream_writer #(.BUF_WORDS(BUF)) dut (
      .clk_clk        (clk),
      .reset_reset_n  (rst_n),
      .enable         (enable),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .avm_address    (avm_address),
      .avm_burstcount (avm_burstcount),
      .avm_write      (avm_write),
      .avm_writedata  (avm_writedata),
      .avm_byteenable (avm_byteenable),
      .avm_waitrequest(wt),
      .wr_ptr         (wr_ptr),
      .burst_done     (burst_done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: words held, burst in progress, ring pointer, flush request.
   logic [31:0] mq[$];
   bit          m_busy;
   bit          m_flush;
   bit          m_acc;
   int          m_left;
   int          m_bc;
   int          m_ptr;
   logic [31:0] m_addr;

   // Observations of the DUT for per-phase checks.
   int          n_done;
   bit          prev_wr;
   logic [31:0] st_addr[$];
   int          st_bc[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_busy  = 0;
      m_flush = 0;
      m_acc   = 0;
      m_left  = 0;
      m_bc    = 0;
      m_ptr   = 0;
      m_addr  = BASE;
   endfunction

   function automatic bit model_can_start();
      return enable && (mq.size() >= BLEN || (m_flush && mq.size() > 0));
   endfunction

   function automatic int min3(input int a, input int b, input int c);
      int r;
      r = a;
      if (b < r) r = b;
      if (c < r) r = c;
      return r;
   endfunction

   task automatic check_outputs();
      bit rdy;
      rdy = rst_n && enable && (mq.size() < DEPTH);
      chk("in_ready",   in_ready,       rdy);
      chk("avm_write",  avm_write,      m_busy);
      chk("address",    avm_address,    m_addr);
      chk("burstcount", avm_burstcount, m_bc);
      chk("wr_ptr",     wr_ptr,         m_ptr);
      chk("burst_done", burst_done,     m_busy && !wt && m_left == 1);
      if (m_busy && mq.size() > 0) chk("writedata", avm_writedata, mq[0]);
      if (burst_done) n_done++;
      if (avm_write && !prev_wr) begin
         st_addr.push_back(avm_address);
         st_bc.push_back(int'(avm_burstcount));
      end
      prev_wr = avm_write;
   endtask

   task automatic model_step();
      int sz;
      int n;
      bit rdy;
      if (!rst_n) begin
         model_reset();
         return;
      end
      sz    = mq.size();
      rdy   = enable && (sz < DEPTH);
      m_acc = in_valid && rdy;
      if (m_busy) begin
         if (!wt) begin
            void'(mq.pop_front());
            m_left--;
            if (m_left == 0) begin
               m_ptr  = (m_ptr + m_bc) % BUF;
               m_busy = 0;
            end
         end
      end else if (enable && (sz >= BLEN || (m_flush && sz > 0))) begin
         n      = min3(BLEN, sz, BUF - m_ptr);
         m_busy = 1;
         m_left = n;
         m_bc   = n;
         m_addr = BASE + 32'(4 * m_ptr);
         if (m_flush && sz < BLEN) m_flush = 0;
      end
      if (flush) m_flush = (sz != 0);
      if (m_acc) mq.push_back(in_data);
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_obs();
      n_done = 0;
      st_addr.delete();
      st_bc.delete();
   endtask

   task automatic push_words(input int n, input logic [31:0] first, input bit rnd_wait);
      int guard;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = first + 32'(i);
         guard    = 0;
         do begin
            if (rnd_wait) wt = 1'($urandom_range(0, 1));
            cycle();
            guard++;
         end while (!m_acc && guard < 200);
         if (!m_acc) chk("push_timeout", 1, 0);
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input bit rnd_wait);
      int guard;
      in_valid = 1'b0;
      guard    = 0;
      while ((m_busy || model_can_start()) && guard < 1000) begin
         if (rnd_wait) wt = 1'($urandom_range(0, 1));
         cycle();
         guard++;
      end
      if (guard >= 1000) chk("drain_timeout", 1, 0);
      wt = 1'b0;
      cycle();
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      cycle();
      flush = 1'b0;
   endtask

   initial begin
      int acc;
      int guard;
      logic [31:0] d;
      rst_n    = 1'b0;
      enable   = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      wt       = 1'b0;
      prev_wr  = 1'b0;
      model_reset();
      clear_obs();
      repeat (3) cycle();
      chk("byteenable", avm_byteenable, 4'hF);
      rst_n  = 1'b1;
      enable = 1'b1;

      // Single aligned burst of 0..7.
      clear_obs();
      push_words(8, 32'd0, 1'b0);
      drain(1'b0);
      chk("t1_bursts", n_done, 1);
      chk("t1_wr_ptr", wr_ptr, 8);
      if (st_addr.size() > 0) begin
         chk("t1_addr", st_addr[0], 32'h3000_0000);
         chk("t1_bc", st_bc[0], 8);
      end else chk("t1_no_burst", 0, 1);

      // Same under random stalls; ends exactly at the ring end.
      clear_obs();
      push_words(8, 32'd100, 1'b1);
      drain(1'b1);
      chk("t2_bursts", n_done, 1);
      chk("t2_wr_ptr", wr_ptr, 0);

      // Slave stalled: FIFO fills to depth, then drains as 8 bursts in order.
      clear_obs();
      wt       = 1'b1;
      acc      = 0;
      d        = 32'd200;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 80; i++) begin
         cycle();
         if (m_acc) begin
            acc++;
            d++;
            in_data = d;
         end
      end
      in_valid = 1'b0;
      chk("t3_accepted", acc, 64);
      chk("t3_in_ready_low", in_ready, 0);
      wt = 1'b0;
      drain(1'b0);
      chk("t3_bursts", n_done, 8);
      chk("t3_wr_ptr", wr_ptr, 0);

      // Flush of a 3-word residue, then flush with nothing buffered.
      clear_obs();
      push_words(3, 32'd300, 1'b0);
      repeat (3) cycle();
      chk("t4_no_early_burst", n_done, 0);
      pulse_flush();
      drain(1'b0);
      chk("t4_bursts", n_done, 1);
      chk("t4_wr_ptr", wr_ptr, 3);
      if (st_bc.size() > 0) chk("t4_bc", st_bc[0], 3);
      clear_obs();
      pulse_flush();
      repeat (10) cycle();
      chk("t4_empty_flush", n_done, 0);
      chk("t4_wr_ptr_hold", wr_ptr, 3);

      // Move to slot 13, then split a burst across the ring end.
      push_words(2, 32'd400, 1'b0);
      pulse_flush();
      drain(1'b0);
      push_words(8, 32'd410, 1'b0);
      drain(1'b0);
      chk("t5_pre_ptr", wr_ptr, 13);
      clear_obs();
      push_words(8, 32'd500, 1'b0);
      pulse_flush();
      drain(1'b0);
      chk("t5_bursts", n_done, 2);
      chk("t5_wr_ptr", wr_ptr, 5);
      if (st_addr.size() >= 2) begin
         chk("t5_addr0", st_addr[0], 32'h3000_0034);
         chk("t5_bc0", st_bc[0], 3);
         chk("t5_addr1", st_addr[1], 32'h3000_0000);
         chk("t5_bc1", st_bc[1], 5);
      end else chk("t5_burst_count", st_addr.size(), 2);

      // Reset asserted while beat 4 is on the bus.
      push_words(8, 32'd600, 1'b0);
      guard = 0;
      while (!(m_busy && m_left == 5) && guard < 50) begin
         cycle();
         guard++;
      end
      if (guard >= 50) chk("t6_beat4_timeout", 1, 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_write_async", avm_write, 0);
      chk("t6_wr_ptr_async", wr_ptr, 0);
      chk("t6_in_ready_async", in_ready, 0);
      repeat (2) cycle();
      rst_n = 1'b1;
      clear_obs();
      push_words(8, 32'd700, 1'b0);
      drain(1'b0);
      chk("t6_bursts", n_done, 1);
      chk("t6_wr_ptr", wr_ptr, 8);
      if (st_addr.size() > 0) begin
         chk("t6_addr", st_addr[0], BASE);
         chk("t6_bc", st_bc[0], 8);
      end else chk("t6_no_burst", 0, 1);

      // Random soak: enable toggling, stalls, flushes, random data.
      for (int i = 0; i < 1500; i++) begin
         enable   = ($urandom_range(0, 9) != 0);
         in_valid = 1'($urandom_range(0, 1));
         in_data  = $urandom;
         wt       = ($urandom_range(0, 2) == 0);
         flush    = ($urandom_range(0, 40) == 0);
         cycle();
      end
      enable   = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      wt       = 1'b0;
      pulse_flush();
      drain(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
